// File: rtl/sp3_link_ctrl_pkg.sv
// Shared types and widths for the SPROCKET3 link bring-up sequencer.
package sp3_link_ctrl_pkg;

   typedef logic [2:0] state_t;

   localparam state_t StIdle       = 3'd0;
   localparam state_t StReset      = 3'd1;
   localparam state_t StWaitMgt    = 3'd2;
   localparam state_t StWaitUplink = 3'd3;
   localparam state_t StLocked     = 3'd4;
   localparam state_t StFail       = 3'd5;

   localparam int unsigned LossCntW  = 16;
   localparam int unsigned RetryCntW = 4;

endpackage

// File: rtl/sp3_link_ctrl_if.sv
// Control/status bundle between the link sequencer (master) and the receiver side (slave).
interface sp3_link_ctrl_if;
   import sp3_link_ctrl_pkg::*;

   logic                 enable_i;
   logic                 restart_i;
   logic [1:0]           chan_en_i;
   logic                 mgt_rxrdy_i;
   logic [1:0]           uplink_rdy_i;
   logic                 uplink_rst_o;
   logic                 link_up_o;
   logic                 fail_o;
   state_t               state_o;
   logic [RetryCntW-1:0] retry_cnt_o;
   logic [LossCntW-1:0]  loss_cnt_o;

   modport master (
      input  enable_i, restart_i, chan_en_i, mgt_rxrdy_i, uplink_rdy_i,
      output uplink_rst_o, link_up_o, fail_o, state_o, retry_cnt_o, loss_cnt_o
   );

   modport slave (
      output enable_i, restart_i, chan_en_i, mgt_rxrdy_i, uplink_rdy_i,
      input  uplink_rst_o, link_up_o, fail_o, state_o, retry_cnt_o, loss_cnt_o
   );

endinterface

// File: rtl/sp3_link_timer.sv
// Up-counter with synchronous clear that holds at, and flags, a runtime terminal count.
module sp3_link_timer #(
   parameter int unsigned Width = 8
) (
   input  logic             axi_clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [Width-1:0] tc_val_i,
   output logic             tc_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == tc_val_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge axi_clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sp3_link_ctrl.sv
// SPROCKET3 uplink bring-up and recovery sequencer: timed phases, bounded retries,
// glitch-filtered loss detection while locked.
module sp3_link_ctrl
   import sp3_link_ctrl_pkg::*;
#(
   parameter int unsigned RST_CYCLES     = 64,
   parameter int unsigned MGT_TIMEOUT    = 1000000,
   parameter int unsigned UPLINK_TIMEOUT = 1000000,
   parameter int unsigned LOSS_FILTER    = 8,
   parameter int unsigned MAX_RETRIES    = 7
) (
   input  logic             axi_clk,
   input  logic             reset,
   sp3_link_ctrl_if.master  link
);

   localparam int unsigned WaitMax  = (MGT_TIMEOUT > UPLINK_TIMEOUT) ? MGT_TIMEOUT : UPLINK_TIMEOUT;
   localparam int unsigned PhaseMax = (WaitMax > RST_CYCLES) ? WaitMax : RST_CYCLES;
   localparam int unsigned PhaseW   = $clog2(PhaseMax) + 1;
   localparam int unsigned FiltW    = $clog2(LOSS_FILTER) + 1;

   state_t               state_q, state_d;
   logic [RetryCntW-1:0] retry_q, retry_d;
   logic [LossCntW-1:0]  loss_q, loss_d;
   logic                 uplink_rst_q, link_up_q, fail_q;

   logic              phase_clr, phase_en, phase_tc;
   logic [PhaseW-1:0] phase_tc_val;
   logic              loss, lock_ok, filt_tc;

   assign lock_ok = ((link.uplink_rdy_i & link.chan_en_i) == link.chan_en_i) && link.mgt_rxrdy_i;
   assign loss    = !link.mgt_rxrdy_i || |(link.chan_en_i & ~link.uplink_rdy_i);
   assign phase_en = (state_q == StReset) || (state_q == StWaitMgt) || (state_q == StWaitUplink);

   always_comb begin
      case (state_q)
         StReset:      phase_tc_val = PhaseW'(RST_CYCLES - 1);
         StWaitMgt:    phase_tc_val = PhaseW'(MGT_TIMEOUT - 1);
         StWaitUplink: phase_tc_val = PhaseW'(UPLINK_TIMEOUT - 1);
         default:      phase_tc_val = '1;
      endcase
   end

   sp3_link_timer #(.Width(PhaseW)) u_phase_timer (
      .axi_clk  (axi_clk),
      .reset    (reset),
      .clr_i    (phase_clr),
      .en_i     (phase_en),
      .tc_val_i (phase_tc_val),
      .tc_o     (phase_tc)
   );

   // Any good cycle, or being outside LOCKED, restarts the loss filter.
   sp3_link_timer #(.Width(FiltW)) u_loss_filter (
      .axi_clk  (axi_clk),
      .reset    (reset),
      .clr_i    ((state_q != StLocked) || !loss),
      .en_i     (1'b1),
      .tc_val_i (FiltW'(LOSS_FILTER - 1)),
      .tc_o     (filt_tc)
   );

   always_comb begin
      state_d   = state_q;
      retry_d   = retry_q;
      loss_d    = loss_q;
      phase_clr = 1'b0;
      if (!link.enable_i) begin
         state_d   = StIdle;
         retry_d   = '0;
         phase_clr = 1'b1;
      end else if (link.restart_i && (state_q != StIdle)) begin
         state_d   = StReset;
         retry_d   = '0;
         phase_clr = 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               state_d   = StReset;
               phase_clr = 1'b1;
            end
            StReset: begin
               if (phase_tc) begin
                  state_d   = StWaitMgt;
                  phase_clr = 1'b1;
               end
            end
            StWaitMgt: begin
               if (link.mgt_rxrdy_i) begin
                  state_d   = StWaitUplink;
                  phase_clr = 1'b1;
               end else if (phase_tc) begin
                  state_d   = (retry_q == RetryCntW'(MAX_RETRIES)) ? StFail : StReset;
                  retry_d   = (retry_q == RetryCntW'(MAX_RETRIES)) ? retry_q : retry_q + 1'b1;
                  phase_clr = 1'b1;
               end
            end
            StWaitUplink: begin
               if (lock_ok) begin
                  state_d   = StLocked;
                  retry_d   = '0;
                  phase_clr = 1'b1;
               end else if (!link.mgt_rxrdy_i || phase_tc) begin
                  state_d   = (retry_q == RetryCntW'(MAX_RETRIES)) ? StFail : StReset;
                  retry_d   = (retry_q == RetryCntW'(MAX_RETRIES)) ? retry_q : retry_q + 1'b1;
                  phase_clr = 1'b1;
               end
            end
            StLocked: begin
               // Loss recovery re-runs bring-up without spending a retry.
               if (loss && filt_tc) begin
                  state_d   = StReset;
                  loss_d    = (loss_q == '1) ? loss_q : loss_q + 1'b1;
                  phase_clr = 1'b1;
               end
            end
            StFail: state_d = StFail;
            default: begin
               state_d   = StIdle;
               phase_clr = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge axi_clk) begin
      if (reset) begin
         state_q      <= StIdle;
         retry_q      <= '0;
         loss_q       <= '0;
         uplink_rst_q <= 1'b1;
         link_up_q    <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         retry_q      <= retry_d;
         loss_q       <= loss_d;
         uplink_rst_q <= (state_d == StIdle) || (state_d == StReset) || (state_d == StFail);
         link_up_q    <= (state_d == StLocked);
         fail_q       <= (state_d == StFail);
      end
   end

   assign link.state_o      = state_q;
   assign link.retry_cnt_o  = retry_q;
   assign link.loss_cnt_o   = loss_q;
   assign link.uplink_rst_o = uplink_rst_q;
   assign link.link_up_o    = link_up_q;
   assign link.fail_o       = fail_q;

endmodule

// File: tb/tb_sp3_link_ctrl.sv
// Directed bench for sp3_link_ctrl with small timing parameters.
module tb_sp3_link_ctrl;
   import sp3_link_ctrl_pkg::*;

   logic axi_clk = 1'b0;
   logic reset   = 1'b1;
   int   total   = 0;
   int   bad     = 0;

   sp3_link_ctrl_if lif ();

   sp3_link_ctrl #(
      .RST_CYCLES     (4),
      .MGT_TIMEOUT    (20),
      .UPLINK_TIMEOUT (30),
      .LOSS_FILTER    (3),
      .MAX_RETRIES    (2)
   ) dut (
      .axi_clk (axi_clk),
      .reset   (reset),
      .link    (lif.master)
   );

   initial forever #5 axi_clk = ~axi_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   task automatic tick();
      @(posedge axi_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
      int n = 0;
      while (lif.state_o !== target && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(lif.state_o), 32'(target));
   endtask

   initial begin
      lif.enable_i     = 1'b0;
      lif.restart_i    = 1'b0;
      lif.chan_en_i    = 2'b11;
      lif.mgt_rxrdy_i  = 1'b0;
      lif.uplink_rdy_i = 2'b00;
      tick();
      tick();
      chk("rst_state", 32'(lif.state_o), 0);
      chk("rst_uplink_rst", 32'(lif.uplink_rst_o), 1);
      chk("rst_link_up", 32'(lif.link_up_o), 0);
      chk("rst_fail", 32'(lif.fail_o), 0);
      chk("rst_retry", 32'(lif.retry_cnt_o), 0);
      chk("rst_loss", 32'(lif.loss_cnt_o), 0);
      reset = 1'b0;
      tick();
      chk("idle_hold", 32'(lif.state_o), 0);

      // 1: nominal bring-up
      lif.enable_i = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         chk("t1_reset_state", 32'(lif.state_o), 1);
         chk("t1_reset_pulse", 32'(lif.uplink_rst_o), 1);
      end
      tick();
      chk("t1_wait_mgt", 32'(lif.state_o), 2);
      chk("t1_rst_low", 32'(lif.uplink_rst_o), 0);
      repeat (5) tick();
      chk("t1_still_mgt", 32'(lif.state_o), 2);
      lif.mgt_rxrdy_i = 1'b1;
      tick();
      chk("t1_wait_uplink", 32'(lif.state_o), 3);
      repeat (10) tick();
      chk("t1_still_uplink", 32'(lif.state_o), 3);
      lif.uplink_rdy_i = 2'b11;
      tick();
      chk("t1_locked", 32'(lif.state_o), 4);
      chk("t1_link_up", 32'(lif.link_up_o), 1);
      chk("t1_retry", 32'(lif.retry_cnt_o), 0);
      chk("t1_rst_low_locked", 32'(lif.uplink_rst_o), 0);

      // 3: loss filter
      lif.uplink_rdy_i = 2'b01;
      tick();
      tick();
      lif.uplink_rdy_i = 2'b11;
      tick();
      chk("t3_glitch_state", 32'(lif.state_o), 4);
      chk("t3_glitch_loss", 32'(lif.loss_cnt_o), 0);
      lif.uplink_rdy_i = 2'b01;
      tick();
      tick();
      chk("t3_filtering", 32'(lif.state_o), 4);
      tick();
      chk("t3_loss_state", 32'(lif.state_o), 1);
      chk("t3_loss_cnt", 32'(lif.loss_cnt_o), 1);
      chk("t3_link_down", 32'(lif.link_up_o), 0);
      chk("t3_loss_retry", 32'(lif.retry_cnt_o), 0);
      lif.uplink_rdy_i = 2'b11;
      wait_state(3'd4, 20, "t3_relock");

      // 4: channel mask
      lif.chan_en_i    = 2'b01;
      lif.uplink_rdy_i = 2'b01;
      lif.restart_i    = 1'b1;
      tick();
      lif.restart_i = 1'b0;
      chk("t4_restart", 32'(lif.state_o), 1);
      wait_state(3'd4, 20, "t4_lock_a_only");
      repeat (5) tick();
      chk("t4_b_ignored", 32'(lif.state_o), 4);
      chk("t4_b_no_loss", 32'(lif.loss_cnt_o), 1);
      lif.chan_en_i    = 2'b00;
      lif.uplink_rdy_i = 2'b00;
      lif.restart_i    = 1'b1;
      tick();
      lif.restart_i = 1'b0;
      repeat (3) tick();
      chk("t4_reset_end", 32'(lif.state_o), 1);
      tick();
      chk("t4_mgt", 32'(lif.state_o), 2);
      tick();
      chk("t4_uplink", 32'(lif.state_o), 3);
      tick();
      chk("t4_nochan_lock", 32'(lif.state_o), 4);
      repeat (4) tick();
      chk("t4_nochan_hold", 32'(lif.state_o), 4);

      // 5: priority, then reset while locked
      lif.chan_en_i = 2'b11;
      lif.restart_i = 1'b1;
      tick();
      lif.restart_i = 1'b0;
      repeat (4) tick();
      tick();
      chk("t5_uplink", 32'(lif.state_o), 3);
      lif.restart_i = 1'b1;
      lif.enable_i  = 1'b0;
      tick();
      lif.restart_i = 1'b0;
      lif.enable_i  = 1'b1;
      chk("t5_prio_idle", 32'(lif.state_o), 0);
      chk("t5_prio_rst", 32'(lif.uplink_rst_o), 1);
      lif.uplink_rdy_i = 2'b11;
      wait_state(3'd4, 20, "t5_relock");
      reset = 1'b1;
      tick();
      chk("t5_sr_state", 32'(lif.state_o), 0);
      chk("t5_sr_uplink_rst", 32'(lif.uplink_rst_o), 1);
      chk("t5_sr_link_up", 32'(lif.link_up_o), 0);
      chk("t5_sr_fail", 32'(lif.fail_o), 0);
      chk("t5_sr_retry", 32'(lif.retry_cnt_o), 0);
      chk("t5_sr_loss", 32'(lif.loss_cnt_o), 0);

      // 6: MGT drop in WAIT_UPLINK
      lif.uplink_rdy_i = 2'b00;
      reset = 1'b0;
      tick();
      repeat (3) tick();
      tick();
      tick();
      chk("t6_uplink", 32'(lif.state_o), 3);
      lif.mgt_rxrdy_i = 1'b0;
      tick();
      chk("t6_state", 32'(lif.state_o), 1);
      chk("t6_retry", 32'(lif.retry_cnt_o), 1);
      chk("t6_rst", 32'(lif.uplink_rst_o), 1);

      // 2: MGT timeout to FAIL
      lif.restart_i = 1'b1;
      tick();
      lif.restart_i = 1'b0;
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk("t2_pulse_state", 32'(lif.state_o), 1);
            chk("t2_pulse_rst", 32'(lif.uplink_rst_o), 1);
            chk("t2_retry", 32'(lif.retry_cnt_o), 32'(p));
         end
         for (int j = 0; j < 20; j++) begin
            tick();
            chk("t2_wait_mgt", 32'(lif.state_o), 2);
            if (j == 0) chk("t2_rst_low", 32'(lif.uplink_rst_o), 0);
         end
         tick();
      end
      chk("t2_fail_state", 32'(lif.state_o), 5);
      chk("t2_fail", 32'(lif.fail_o), 1);
      chk("t2_fail_rst", 32'(lif.uplink_rst_o), 1);
      chk("t2_fail_retry", 32'(lif.retry_cnt_o), 2);
      repeat (3) tick();
      chk("t2_fail_sticky", 32'(lif.state_o), 5);
      lif.restart_i = 1'b1;
      tick();
      lif.restart_i = 1'b0;
      chk("t2_restart_state", 32'(lif.state_o), 1);
      chk("t2_restart_fail", 32'(lif.fail_o), 0);
      chk("t2_restart_retry", 32'(lif.retry_cnt_o), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sp3_link_ctrl.md
Name: sp3_link_ctrl

Overview:
- Link bring-up and recovery sequencer for the SPROCKET3 dual receiver.
- Drives the receiver's uplink reset (uplinkRst_i) and watches three ready flags, already synchronized into axi_clk: MGT Rx ready, uplink A ready and uplink B ready.
- Brings the link up with a timeout on each phase, retries a bounded number of times, then latches a failure.
- While locked, it filters loss-of-ready glitches, counts real losses and re-runs the bring-up sequence.

Parameters:
- RST_CYCLES, 64: cycles uplink_rst_o is held high in RESET.
- MGT_TIMEOUT, 1000000: max cycles in WAIT_MGT before a retry.
- UPLINK_TIMEOUT, 1000000: max cycles in WAIT_UPLINK before a retry.
- LOSS_FILTER, 8: consecutive cycles a required ready must be low in LOCKED before loss is declared.
- MAX_RETRIES, 7: retries allowed before entering FAIL.

Ports:
- axi_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- enable_i  in  1  run the sequencer; low forces IDLE.
- restart_i  in  1  single-cycle request to restart bring-up and clear FAIL.
- chan_en_i  in  2  uplink channels required for lock; [0]=A, [1]=B.
- mgt_rxrdy_i  in  1  MGT Rx ready.
- uplink_rdy_i  in  2  lpGBT uplink ready; [0]=A, [1]=B.
- uplink_rst_o  out  1  uplink reset to the receiver.
- link_up_o  out  1  high in LOCKED.
- fail_o  out  1  high in FAIL.
- state_o  out  3  current state encoding.
- retry_cnt_o  out  4  retries used in the current attempt sequence.
- loss_cnt_o  out  16  saturating count of loss-of-lock events.

Behaviour:
- All outputs are registered and change on the cycle after the state transition.
- Reset values:
  - state IDLE (0).
  - uplink_rst_o=1.
  - link_up_o=0, fail_o=0.
  - retry_cnt_o=0, loss_cnt_o=0.
  - Phase timer=0.
- State encodings: IDLE=0, RESET=1, WAIT_MGT=2, WAIT_UPLINK=3, LOCKED=4, FAIL=5.
- uplink_rst_o is 1 in IDLE, RESET and FAIL; 0 otherwise.
- The phase timer clears on every state change.
- Priority, highest first:
  1. enable_i=0: go to IDLE; clear retry_cnt.
  2. restart_i=1 in any state other than IDLE: go to RESET; clear retry_cnt.
  3. Normal transitions, listed below.
- IDLE: enable_i=1 -> RESET.
- RESET: stays exactly RST_CYCLES cycles, then -> WAIT_MGT.
- WAIT_MGT:
  - mgt_rxrdy_i=1 -> WAIT_UPLINK.
  - Otherwise, when the timer reaches MGT_TIMEOUT-1 -> RETRY.
- WAIT_UPLINK:
  - If (uplink_rdy_i & chan_en_i) == chan_en_i and mgt_rxrdy_i=1 -> LOCKED. With chan_en_i=0 this happens on the first WAIT_UPLINK cycle.
  - mgt_rxrdy_i=0 -> RETRY immediately.
  - Timer reaching UPLINK_TIMEOUT-1 -> RETRY.
- RETRY is a decision, not a state, taken in the same cycle:
  - If retry_cnt == MAX_RETRIES -> FAIL.
  - Otherwise retry_cnt+1 and -> RESET.
- LOCKED:
  - Entering LOCKED clears retry_cnt.
  - A loss condition is mgt_rxrdy_i=0 or any channel enabled in chan_en_i with uplink_rdy_i=0.
  - The loss condition must hold for LOSS_FILTER consecutive cycles; any good cycle clears the filter counter.
  - When the filter expires: loss_cnt+1 (saturating at 16'hFFFF), then -> RESET. This transition does not consume a retry.
  - A chan_en_i change while in LOCKED takes effect in the loss check immediately.
- FAIL: sticky until restart_i=1 or enable_i=0.
- Timer width is $clog2 of max(MGT_TIMEOUT, UPLINK_TIMEOUT, RST_CYCLES) + 1. Timers never wrap, because every phase exits at its limit.

Decomposition:
- Package sp3_link_ctrl_pkg holds:
  - the state enum (typedef logic [2:0]) with the encodings above;
  - the loss_cnt width constant;
  - the retry_cnt width constant.
- One sub-module, sp3_link_timer: a parameterized up-counter with a synchronous clear and a terminal-count flag. It is instantiated for the phase timer and for the loss filter.

Test Plan:
All scenarios use RST_CYCLES=4, MGT_TIMEOUT=20, UPLINK_TIMEOUT=30, LOSS_FILTER=3, MAX_RETRIES=2, chan_en_i=2'b11.
1. Nominal bring-up:
   - Stimulus: enable_i=1; mgt_rxrdy_i rises 5 cycles after uplink_rst_o falls; uplink_rdy_i=2'b11 10 cycles later.
   - Required: uplink_rst_o high exactly 4 cycles; then state 2, 3, 4; link_up_o=1; retry_cnt_o=0.
2. MGT timeout to FAIL:
   - Stimulus: enable_i=1; mgt_rxrdy_i held 0.
   - Required: three RESET pulses of 4 cycles each, 20 cycles apart; retry_cnt_o reads 1 then 2; then fail_o=1, state_o=5, uplink_rst_o=1.
   - Then restart_i pulse -> state 1, fail_o=0, retry_cnt_o=0.
3. Loss filter in LOCKED:
   - Stimulus: uplink_rdy_i[1] low for 2 cycles.
   - Required: stays LOCKED, loss_cnt_o=0.
   - Stimulus: uplink_rdy_i[1] low for 3 cycles.
   - Required: -> RESET, loss_cnt_o=1, link_up_o=0.
4. Channel mask:
   - Stimulus: chan_en_i=2'b01, uplink_rdy_i=2'b01.
   - Required: LOCKED reached; dropping uplink_rdy_i[1] has no effect.
   - Stimulus: chan_en_i=2'b00.
   - Required: LOCKED one cycle after WAIT_UPLINK is entered.
5. Priority and reset mid-operation:
   - Stimulus: restart_i and enable_i=0 in the same cycle during WAIT_UPLINK.
   - Required: IDLE.
   - Stimulus: synchronous reset asserted in LOCKED.
   - Required: every output at its reset value next cycle, including loss_cnt_o=0.
6. MGT drop while waiting:
   - Stimulus: mgt_rxrdy_i falls in WAIT_UPLINK.
   - Required: RESET next cycle, retry_cnt_o=1.
